// File: rtl/output_arbiter.sv
// output_arbiter: per-output switch stage of the NoC router.
// Picks one non-empty input buffer by round-robin and holds the grant from
// head flit to tail flit. Pops flits with a one-hot read strobe and
// registers them onto the output link. Sends are gated by a credit counter
// that tracks free slots in the next hop's input buffer.
module output_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CREDITS    = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_empty_i,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data_i,
  output logic [NUM_INPUTS-1:0]            in_read_o,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic                             out_valid_o,
  input  logic                             credit_return_i,
  output logic [NUM_INPUTS-1:0]            grant_o,
  output logic                             credit_err_o
);

  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  // Flit type lives in the top two bits. Bit 0 set means the flit ends a
  // packet (tail or single).
  localparam logic [1:0] FT_HEAD = 2'b10;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [CW-1:0]           credits_q, credits_d;
  logic [NUM_INPUTS-1:0]   grant_q, grant_d;
  logic                    credit_err_q, credit_err_d;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_valid_q;

  logic                    can_send;
  logic                    scan_found;
  logic [IW-1:0]           scan_idx;
  logic                    read_en;
  logic [IW-1:0]           read_idx;
  logic [DATA_WIDTH-1:0]   flit;
  logic [1:0]              flit_type;

  // Wrap-around increment of an input index.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_INPUTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Only the registered count matters, so a credit returned this cycle is
  // usable from the next cycle.
  assign can_send = (credits_q != '0);

  // Round-robin scan: first non-empty input starting at rr_ptr.
  always_comb begin
    int j;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    scan_found = 1'b0;
    scan_idx   = rr_ptr_q;
    j          = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
      if (!scan_found && !in_empty_i[j]) begin
        scan_found = 1'b1;
        scan_idx   = IW'(j);
      end
    end
  end

  // Read decision: the scan winner in IDLE, only the owner while LOCKED.
  always_comb begin
    read_en  = 1'b0;
    read_idx = rr_ptr_q;
    if (can_send) begin
      if (state_q == IDLE) begin
        read_en  = scan_found;
        read_idx = scan_idx;
      end else begin
        read_en  = !in_empty_i[owner_q];
        read_idx = owner_q;
      end
    end
  end

  assign flit      = in_data_i[int'(read_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign flit_type = flit[DATA_WIDTH-1 -: 2];

  // One-hot pop strobe. It is gated by reset because the reset state
  // (IDLE, full credits) would otherwise pop a non-empty buffer while the
  // link is held in reset.
  always_comb begin
    in_read_o = '0;
    if (read_en && reset) in_read_o[read_idx] = 1'b1;
  end

  // Next-state for the packet lock, round-robin pointer and credit counter.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;

    if (read_en) begin
      if (state_q == IDLE) begin
        if (flit_type == FT_HEAD) begin
          state_d = LOCKED;
          owner_d = read_idx;
          grant_d = NUM_INPUTS'(1) << read_idx;
        end else begin
          // Single flit, or a stray body/tail that is forwarded as single.
          rr_ptr_d = next_idx(read_idx);
        end
      end else if (flit_type[0]) begin
        state_d  = IDLE;
        rr_ptr_d = next_idx(owner_q);
        grant_d  = '0;
      end
    end

    case ({read_en, credit_return_i})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CREDIT_MAX) credit_err_d = 1'b1;
        else                         credits_d    = credits_q + 1'b1;
      end
      default: credits_d = credits_q;
    endcase
  end

  // Single state register for the FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      credits_q    <= CREDIT_MAX;
      grant_q      <= '0;
      credit_err_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      credits_q    <= credits_d;
      grant_q      <= grant_d;
      credit_err_q <= credit_err_d;
      out_valid_q  <= read_en;
      if (read_en) out_data_q <= flit;
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign grant_o      = grant_q;
  assign credit_err_o = credit_err_q;

endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: bench-side FIFOs model the input buffers; expected
// output flits are queued when stimulus is loaded and compared as they
// appear on the output link.
module tb_output_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_empty_i;
  logic [N*DW-1:0] in_data_i;
  logic [N-1:0]    in_read_o;
  logic [DW-1:0]   out_data_o;
  logic            out_valid_o;
  logic            credit_return_i;
  logic [N-1:0]    grant_o;
  logic            credit_err_o;

  output_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .CREDITS(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_empty_i      (in_empty_i),
    .in_data_i       (in_data_i),
    .in_read_o       (in_read_o),
    .out_data_o      (out_data_o),
    .out_valid_o     (out_valid_o),
    .credit_return_i (credit_return_i),
    .grant_o         (grant_o),
    .credit_err_o    (credit_err_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo [N][$];
  logic [DW-1:0] exp_q [$];
  logic [N-1:0]  last_rd;
  logic [N-1:0]  last_grant;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      in_empty_i[i] = (fifo[i].size() == 0);
      in_data_i[i*DW +: DW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  // One clock: compare any output flit, sample strobe/grant, then pop the
  // buffers that were read at the edge.
  task automatic step();
    @(negedge clk);
    if (out_valid_o) begin
      if (exp_q.size() == 0) check("out_extra", {31'b0, out_valid_o}, 32'd0);
      else                   check("out_data", {16'b0, out_data_o}, {16'b0, exp_q.pop_front()});
    end
    last_rd    = in_read_o;
    last_grant = grant_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (last_rd[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    credit_return_i = 1'b0;
    drive_inputs();
  endtask

  task automatic rd_step(input string tag, input logic [N-1:0] exp_rd);
    step();
    check(tag, {28'b0, last_rd}, {28'b0, exp_rd});
  endtask

  task automatic drain(input string tag);
    check(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    credit_return_i = 1'b0;
    for (int i = 0; i < N; i++) fifo[i].delete();
    exp_q.delete();
    drive_inputs();
    #1;
    check("rst_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_grant", {28'b0, grant_o}, 32'd0);
    check("rst_err", {31'b0, credit_err_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    credit_return_i = 1'b0;
    in_empty_i = '1;
    in_data_i = '0;

    // T1: single flit on input 2, then rr_ptr = 3 and credit exhaustion.
    do_reset();
    fifo[2].push_back(16'hC0AB);
    exp_q.push_back(16'hC0AB);
    drive_inputs();
    rd_step("t1_rd_in2", 4'b0100);
    check("t1_grant0", {28'b0, last_grant}, 32'd0);
    fifo[3] = '{16'hC031, 16'hC032, 16'hC033, 16'hC034};
    fifo[0].push_back(16'hC001);
    exp_q.push_back(16'hC031); exp_q.push_back(16'hC001);
    exp_q.push_back(16'hC032); exp_q.push_back(16'hC033);
    exp_q.push_back(16'hC034);
    drive_inputs();
    rd_step("t1_rr3", 4'b1000);
    check("t1_grant_single", {28'b0, last_grant}, 32'd0);
    rd_step("t1_rr0", 4'b0001);
    rd_step("t1_rr3b", 4'b1000);
    rd_step("t1_rr3c", 4'b1000);
    rd_step("t1_nocred", 4'b0000);
    credit_return_i = 1'b1;
    rd_step("t1_ret_same", 4'b0000);
    rd_step("t1_ret_next", 4'b1000);
    step();
    drain("t1_drain");

    // T2: two 3-flit packets back-to-back, tail held for a credit.
    do_reset();
    fifo[0] = '{16'h8001, 16'h0002, 16'h4003};
    fifo[1] = '{16'h8011, 16'h0012, 16'h4013};
    exp_q = '{16'h8001, 16'h0002, 16'h4003, 16'h8011, 16'h0012, 16'h4013};
    drive_inputs();
    rd_step("t2_head0", 4'b0001);
    check("t2_grant_idle", {28'b0, last_grant}, 32'd0);
    rd_step("t2_body0", 4'b0001);
    check("t2_grant_lock0", {28'b0, last_grant}, 32'd1);
    rd_step("t2_tail0", 4'b0001);
    rd_step("t2_head1", 4'b0010);
    check("t2_grant_released", {28'b0, last_grant}, 32'd0);
    rd_step("t2_body1", 4'b0010);
    check("t2_grant_lock1", {28'b0, last_grant}, 32'd2);
    rd_step("t2_nocred", 4'b0000);
    credit_return_i = 1'b1;
    rd_step("t2_ret_same", 4'b0000);
    rd_step("t2_tail1", 4'b0010);
    step();
    check("t2_grant_end", {28'b0, last_grant}, 32'd0);
    drain("t2_drain");

    // T3: owner empty inserts bubbles; input 3 waits for the tail.
    do_reset();
    fifo[0].push_back(16'h8021);
    fifo[3].push_back(16'hC0F3);
    exp_q = '{16'h8021, 16'h0022, 16'h4023, 16'hC0F3};
    drive_inputs();
    rd_step("t3_head0", 4'b0001);
    rd_step("t3_bubble1", 4'b0000);
    check("t3_grant_b1", {28'b0, last_grant}, 32'd1);
    rd_step("t3_bubble2", 4'b0000);
    check("t3_grant_b2", {28'b0, last_grant}, 32'd1);
    fifo[0].push_back(16'h0022);
    fifo[0].push_back(16'h4023);
    drive_inputs();
    rd_step("t3_body0", 4'b0001);
    rd_step("t3_tail0", 4'b0001);
    rd_step("t3_in3", 4'b1000);
    check("t3_grant_idle", {28'b0, last_grant}, 32'd0);
    step();
    drain("t3_drain");

    // T4: every input holds singles; grants rotate 0,1,2,3,0.
    do_reset();
    fifo[0] = '{16'hC000, 16'hC001};
    fifo[1].push_back(16'hC010);
    fifo[2].push_back(16'hC020);
    fifo[3].push_back(16'hC030);
    exp_q = '{16'hC000, 16'hC010, 16'hC020, 16'hC030, 16'hC001};
    drive_inputs();
    rd_step("t4_g0", 4'b0001);
    rd_step("t4_g1", 4'b0010);
    rd_step("t4_g2", 4'b0100);
    rd_step("t4_g3", 4'b1000);
    rd_step("t4_g0b", 4'b0001);
    step();
    drain("t4_drain");

    // T5: credit return at full count sets the sticky error, count stays 5.
    do_reset();
    check("t5_err_clear", {31'b0, credit_err_o}, 32'd0);
    credit_return_i = 1'b1;
    step();
    check("t5_err_set", {31'b0, credit_err_o}, 32'd1);
    fifo[1] = '{16'hC051, 16'hC052, 16'hC053, 16'hC054, 16'hC055, 16'hC056};
    exp_q = '{16'hC051, 16'hC052, 16'hC053, 16'hC054, 16'hC055};
    drive_inputs();
    for (int i = 0; i < 5; i++) rd_step("t5_send", 4'b0010);
    rd_step("t5_stall", 4'b0000);
    check("t5_err_sticky", {31'b0, credit_err_o}, 32'd1);
    drain("t5_drain");

    // T6: reset mid-packet while locked on input 1.
    do_reset();
    fifo[1] = '{16'h8051, 16'h0052, 16'h4053};
    exp_q.push_back(16'h8051);
    drive_inputs();
    rd_step("t6_head1", 4'b0010);
    rd_step("t6_body1", 4'b0010);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_valid", {31'b0, out_valid_o}, 32'd0);
    check("t6_async_data", {16'b0, out_data_o}, 32'd0);
    check("t6_async_grant", {28'b0, grant_o}, 32'd0);
    check("t6_async_err", {31'b0, credit_err_o}, 32'd0);
    check("t6_async_read", {28'b0, in_read_o}, 32'd0);
    drain("t6_drain_head");
    fifo[0].push_back(16'hC0D0);
    fifo[2].push_back(16'hC0E2);
    exp_q = '{16'hC0D0, 16'h4053, 16'hC0E2};
    drive_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd_step("t6_rr0", 4'b0001);
    rd_step("t6_stray_tail", 4'b0010);
    rd_step("t6_in2", 4'b0100);
    step();
    check("t6_grant_end", {28'b0, last_grant}, 32'd0);
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
